// File: rtl/mul3_pkg.sv
// mul3_pkg: state codes, widths and sizing helpers for mul3.
// MUL3_RADIX4_EN selects two result bits per step instead of one.
package mul3_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CARRY_W = 2;

`ifdef MUL3_RADIX4_EN
  localparam int DIG_W = 2;
`else
  localparam int DIG_W = 1;
`endif

  // q window {qe[k+DIG_W-1] .. qe[k], qe[k-1]}
  localparam int QW = DIG_W + 1;
  // digit sum width: max 5 (radix-2), max 9 (radix-4)
  localparam int SW = DIG_W + 2;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

  function automatic int step_count(input int n);
    return (n + DIG_W - 1) / DIG_W;
  endfunction

endpackage

// File: rtl/mul3_slice.sv
// mul3_slice: one digit of 3*q + carry, q window in, digit and carry out.
// Ports: qw (q window, LSB = qe[k-1]), cin, d (result bits), cout.
module mul3_slice
  import mul3_pkg::*;
(
  input  logic [QW-1:0]      qw,
  input  logic [CARRY_W-1:0] cin,
  output logic [DIG_W-1:0]   d,
  output logic [CARRY_W-1:0] cout
);

  logic [SW-1:0] s;

`ifdef MUL3_RADIX4_EN
  // 3q = q + 2q over bits k, k+1
  assign s = SW'(qw[1])
           + SW'({qw[2], 1'b0})
           + SW'(qw[0])
           + SW'({qw[1], 1'b0})
           + SW'(cin);
`else
  assign s = SW'(qw[1])
           + SW'(qw[0])
           + SW'(cin);
`endif

  assign d    = s[DIG_W-1:0];
  assign cout = s[SW-1:DIG_W];

endmodule

// File: rtl/mul3.sv
// mul3: bit-serial x = 3*q + r, LSB first, single-shot vld handshake.
// Ports: clk, rst_n, i_q/i_r/i_vld in; o_busy, o_x, o_ovf, o_vld out.
// Build option: MUL3_RADIX4_EN (two result bits per cycle).
module mul3
  import mul3_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-2:0] i_q,
  input  logic [1:0]   i_r,
  input  logic         i_vld,
  output logic         o_busy,
  output logic [N-1:0] o_x,
  output logic         o_ovf,
  output logic         o_vld
);

  localparam int CW    = cnt_width(N);
  localparam int STEPS = step_count(N);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  logic [1:0]         state;
  logic [N-2:0]       q;
  logic [CW-1:0]      cnt;
  logic [CARRY_W-1:0] carry;
  logic [N-1:0]       sbuf;

  logic [N+1:0]       qx;
  logic [QW-1:0]      qw;
  logic [DIG_W-1:0]   d;
  logic [CARRY_W-1:0] cout;
  logic [N-1:0]       nbuf;
  logic [CARRY_W-1:0] ncarry;
  logic               last;

  // qx[i+1] = qe[i]; zero below bit 0 and above q
  assign qx = {2'b00, q, 1'b0};

`ifdef MUL3_RADIX4_EN
  assign qw = QW'(qx >> {cnt, 1'b0});
`else
  assign qw = QW'(qx >> cnt);
`endif

  assign last = (cnt == LAST);

  mul3_slice u_slice (
    .qw   (qw),
    .cin  (carry),
    .d    (d),
    .cout (cout)
  );

  always_comb begin
    nbuf   = {d, sbuf[N-1:DIG_W]};
    ncarry = cout;
`ifdef MUL3_RADIX4_EN
    // odd N: last digit keeps one bit, rest goes to carry
    if ((N % 2) == 1 && last) begin
      nbuf   = {d[0], sbuf[N-1:1]};
      ncarry = {cout[0], d[1]};
    end
`endif
  end

  assign o_busy = (state == STEP) || (state == DONE);
  assign o_vld  = (state == DONE);

  // result regs load on the final step so they
  // already hold the answer while o_vld is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      carry <= '0;
      sbuf  <= '0;
      o_x   <= '0;
      o_ovf <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_vld) begin
            q     <= i_q;
            carry <= i_r;
            cnt   <= '0;
            state <= STEP;
          end
        end
        STEP: begin
          sbuf  <= nbuf;
          carry <= ncarry;
          cnt   <= cnt + 1'b1;
          if (last) begin
            o_x   <= nbuf;
            o_ovf <= |ncarry;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul3.sv
// tb_mul3: scoreboard bench for mul3.
// Expected results queued at accept, compared on o_vld.
`timescale 1ns/1ps
module tb_mul3;

  localparam int N = 8;
`ifdef MUL3_RADIX4_EN
  localparam int LAT = (N + 1) / 2;
`else
  localparam int LAT = N;
`endif

  typedef struct {
    logic [N-1:0] x;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-2:0] i_q = '0;
  logic [1:0]   i_r = '0;
  logic         i_vld = 1'b0;
  logic         o_busy;
  logic [N-1:0] o_x;
  logic         o_ovf;
  logic         o_vld;

  exp_t sb[$];
  exp_t mon_e;
  int   vld_cyc[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   vld_n = 0;
  int   cyc = 0;
  int   base;

  mul3 #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_q    (i_q),
    .i_r    (i_r),
    .i_vld  (i_vld),
    .o_busy (o_busy),
    .o_x    (o_x),
    .o_ovf  (o_ovf),
    .o_vld  (o_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void push(input logic [N-2:0] q,
                               input logic [1:0] r);
    int   f;
    exp_t e;
    f = 3 * int'(q) + int'(r);
    e.x = f[N-1:0];
    e.ovf = (f >= (1 << N));
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst_n && o_vld) begin
      vld_n++;
      vld_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("spurious_vld", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("x", 32'(o_x), 32'(mon_e.x));
        check("ovf", 32'(o_ovf), 32'(mon_e.ovf));
      end
    end
  end

  task automatic op(input logic [N-2:0] q,
                    input logic [1:0] r,
                    input bit tmg);
    int m;
    int busy_n;
    int f;
    bit seen;
    logic [N-1:0] xe;
    @(negedge clk);
    i_q = q;
    i_r = r;
    i_vld = 1'b1;
    @(posedge clk);
    push(q, r);
    f = 3 * int'(q) + int'(r);
    xe = f[N-1:0];
    @(negedge clk);
    i_vld = 1'b0;
    m = 0;
    busy_n = 0;
    seen = 1'b0;
    while (!seen && m < 200) begin
      if (o_busy) busy_n++;
      if (o_vld) seen = 1'b1;
      else begin
        @(negedge clk);
        m++;
      end
    end
    if (!seen) check("timeout", m, LAT);
    if (tmg) begin
      check("latency", m, LAT);
      check("busy_cycles", busy_n, LAT + 1);
    end
    @(negedge clk);
    if (tmg) begin
      check("vld_pulse", 32'(o_vld), 32'd0);
      check("busy_idle", 32'(o_busy), 32'd0);
      check("x_hold", 32'(o_x), 32'(xe));
    end
  endtask

  initial begin
    #3;
    check("rst_x", 32'(o_x), 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);
    check("rst_vld", 32'(o_vld), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(85, 0, 1'b1);
    op(85, 1, 1'b1);
    op(127, 3, 1'b1);
    op(0, 2, 1'b1);
    base = vld_n;
    op(0, 0, 1'b1);
    check("zero_one_vld", vld_n - base, 1);

    // i_vld held high across two operations
    base = vld_n;
    vld_cyc.delete();
    @(negedge clk);
    i_q = 10;
    i_r = 0;
    i_vld = 1'b1;
    @(posedge clk);
    push(10, 0);
    @(negedge clk);
    i_q = 20;
    repeat (LAT + 1) @(posedge clk);
    @(posedge clk);
    push(20, 0);
    @(negedge clk);
    i_vld = 1'b0;
    repeat (2 * LAT + 8) @(negedge clk);
    check("stream_vld_count", vld_n - base, 2);
    if (vld_cyc.size() >= 2)
      check("stream_spacing", vld_cyc[1] - vld_cyc[0], LAT + 2);

    // reset in the middle of an operation
    @(negedge clk);
    i_q = 50;
    i_r = 1;
    i_vld = 1'b1;
    @(posedge clk);
    base = vld_n;
    @(negedge clk);
    i_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_x", 32'(o_x), 32'd0);
    check("abort_ovf", 32'(o_ovf), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_vld", 32'(o_vld), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    check("abort_no_vld", vld_n, base);
    op(50, 1, 1'b1);

    // round trip against div3 outputs
    for (int x = 0; x < (1 << N); x++) begin
      int t;
      int u;
      logic [N-2:0] qq;
      logic [1:0] rr;
      t = x / 3;
      u = x % 3;
      qq = t[N-2:0];
      rr = u[1:0];
      op(qq, rr, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
